// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage, the instruction ROM and the decode/execute stage.
// Also defines the `NOP opcode value when the build does not supply one.
`ifndef NOP
`define NOP 4'h0
`endif

interface instruction_fetch_if #(
   parameter int ADDR_WIDTH  = 16,
   parameter int INSTR_WIDTH = 28
);
   // Transfer rule: a word is handed to decode on every rising edge where oValid=1
   // and iStall=0; iStall is the only back-pressure and freezes every fetch output.
   logic [ADDR_WIDTH-1:0]  oAddress;
   logic [INSTR_WIDTH-1:0] iInstruction;
   logic                   iStall;
   logic                   iBranchTaken;
   logic [ADDR_WIDTH-1:0]  iBranchTarget;
   logic [INSTR_WIDTH-1:0] oInstruction;
   logic [ADDR_WIDTH-1:0]  oPC;
   logic                   oValid;
   logic                   oBusy;
   logic                   dbg_delay;

   modport master (
      output oAddress, oInstruction, oPC, oValid, oBusy, dbg_delay,
      input  iInstruction, iStall, iBranchTaken, iBranchTarget
   );

   modport slave (
      input  oAddress, oInstruction, oPC, oValid, oBusy, dbg_delay,
      output iInstruction, iStall, iBranchTaken, iBranchTarget
   );
endinterface

// File: rtl/instruction_fetch.sv
// PC/fetch stage in front of the instruction ROM: stall, branch flush, and
// (with FETCH_NOP_DELAY_EN defined) multi-cycle NOP delays.
module instruction_fetch #(
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    INSTR_WIDTH  = 28,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input logic                 Clock,
   input logic                 Reset,
   instruction_fetch_if.master bus
);
   localparam int CW = INSTR_WIDTH - 4;
   localparam logic [INSTR_WIDTH-1:0] NOP_WORD = {`NOP, {CW{1'b0}}};
   localparam logic [ADDR_WIDTH-1:0]  PC_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0] pc;

   assign bus.oAddress = pc;

`ifdef FETCH_NOP_DELAY_EN
   typedef enum logic {FETCH = 1'b0, DELAY = 1'b1} state_t;

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t        state;
   logic [CW-1:0] delay_cnt;
   logic [3:0]    opcode;
   logic [CW-1:0] operand;

   assign opcode        = bus.iInstruction[INSTR_WIDTH-1 -: 4];
   assign operand       = bus.iInstruction[CW-1:0];
   assign bus.dbg_delay = (state == DELAY);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc               <= RESET_VECTOR;
         bus.oInstruction <= NOP_WORD;
         bus.oPC          <= '0;
         bus.oValid       <= 1'b0;
         bus.oBusy        <= 1'b0;
         delay_cnt        <= '0;
         state            <= FETCH;
      end else if (bus.iBranchTaken) begin
         pc               <= bus.iBranchTarget;
         bus.oInstruction <= NOP_WORD;
         bus.oValid       <= 1'b0;
         bus.oBusy        <= 1'b0;
         delay_cnt        <= '0;
         state            <= FETCH;
      end else if (!bus.iStall) begin
         if (state == DELAY) begin
            // One bubble per unstalled cycle; the PC already points past the NOP.
            bus.oInstruction <= NOP_WORD;
            bus.oValid       <= 1'b0;
            bus.oBusy        <= 1'b1;
            delay_cnt        <= delay_cnt - CNT_ONE;
            if (delay_cnt == CNT_ONE) state <= FETCH;
         end else begin
            bus.oInstruction <= bus.iInstruction;
            bus.oPC          <= pc;
            bus.oValid       <= 1'b1;
            bus.oBusy        <= 1'b0;
            pc               <= pc + PC_ONE;
            if (opcode == `NOP && operand != '0) begin
               delay_cnt <= operand;
               state     <= DELAY;
            end
         end
      end
   end
`else
   assign bus.oBusy     = 1'b0;
   assign bus.dbg_delay = 1'b0;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc               <= RESET_VECTOR;
         bus.oInstruction <= NOP_WORD;
         bus.oPC          <= '0;
         bus.oValid       <= 1'b0;
      end else if (bus.iBranchTaken) begin
         pc               <= bus.iBranchTarget;
         bus.oInstruction <= NOP_WORD;
         bus.oValid       <= 1'b0;
      end else if (!bus.iStall) begin
         bus.oInstruction <= bus.iInstruction;
         bus.oPC          <= pc;
         bus.oValid       <= 1'b1;
         pc               <= pc + PC_ONE;
      end
   end
`endif
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Program-counter and fetch stage that sits directly upstream of the instruction ROM.
- Drives the ROM address, captures the 28-bit instruction the ROM returns combinationally, and presents it registered to the decode/execute stage together with its PC and a valid flag.
- Handles pipeline stall, branch redirect with flush, and multi-cycle NOP delays.

Parameters:
- ADDR_WIDTH, 16, width of PC and ROM address.
- INSTR_WIDTH, 28, instruction width; opcode is iInstruction[27:24], operand is [23:0].
- RESET_VECTOR, 16'd0, PC value loaded on reset.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- oAddress  output  ADDR_WIDTH  ROM address; equals internal PC (rPC) combinationally.
- iInstruction  input  INSTR_WIDTH  ROM data for oAddress, valid in the same cycle.
- iStall  input  1  downstream stall; holds fetch state.
- iBranchTaken  input  1  redirect request from execute.
- iBranchTarget  input  ADDR_WIDTH  redirect address, sampled when iBranchTaken=1.
- oInstruction  output  INSTR_WIDTH  registered instruction to decode.
- oPC  output  ADDR_WIDTH  address oInstruction was fetched from.
- oValid  output  1  oInstruction is a real instruction (0 = bubble).
- oBusy  output  1  NOP delay in progress.

Behaviour:
- Clock/reset: one clock, Clock. Reset is synchronous and active-high: state changes only on a rising Clock edge with Reset=1.
- Reset values: rPC=RESET_VECTOR; oInstruction={`NOP,24'd0}; oPC=0; oValid=0; oBusy=0; delay counter=0.
- Priority per cycle: Reset > branch > stall > NOP delay > normal fetch.
- Normal fetch:
  - oInstruction<=iInstruction; oPC<=rPC; oValid<=1; rPC<=rPC+1.
  - Latency: rPC=A in cycle n gives ROM[A] on oInstruction in cycle n+1.
- PC arithmetic: unsigned, ADDR_WIDTH bits; 16'hFFFF+1 wraps to 16'h0000 with no flag.
- Branch (iBranchTaken=1):
  - rPC<=iBranchTarget; oInstruction<={`NOP,24'd0}; oValid<=0; delay counter cleared; oBusy<=0.
  - The instruction fetched in the branch cycle is discarded.
  - The target instruction appears valid 2 cycles after the branch cycle.
  - Branch during stall or during a delay takes effect: flush wins.
- Stall (iStall=1, no branch):
  - rPC, oInstruction, oPC and oValid hold.
  - The delay counter also holds.
- States:
  - FETCH: normal operation.
  - DELAY: counter>0.
  - FETCH->DELAY: a `NOP with operand N>0 is issued. The NOP itself is output with oValid=1, rPC advances, and counter<=N.
  - In DELAY: oValid<=0; oInstruction<={`NOP,24'd0}; rPC holds; oBusy=1; counter decrements each unstalled cycle.
  - DELAY->FETCH: when counter reaches 0. Exactly N bubble cycles are inserted.
- NOP operand 0 is a plain single instruction with no delay.
- Non-NOP opcodes never enter DELAY.
- Reset mid-delay or mid-stall returns fully to reset values on that edge.

Optional Feature:
- Macro: FETCH_NOP_DELAY_EN.
- Defined: NOP operand delay behaves as described above; delay counter is 24 bits.
- Undefined: no DELAY state or counter; `NOP is fetched like any other instruction; oBusy is tied to 0.

Test Plan:
- Reset held 3 cycles, then released with ROM ROM[0]=`NOP 0, ROM[1..8] distinct -> oAddress steps 0,1,2,...; oInstruction/oPC match ROM[k]/k one cycle later; oValid=1 from the first post-reset edge+1.
- iStall=1 for 4 cycles while rPC=5 -> oAddress stays 5; oInstruction=ROM[4], oPC=4 held; after release, ROM[5] follows with no skip or duplicate.
- iBranchTaken=1, iBranchTarget=16'd7 while rPC=3 -> next cycle oValid=0 bubble, rPC=7; following cycle oInstruction=ROM[7], oPC=7, oValid=1.
- FETCH_NOP_DELAY_EN defined, ROM[0]={`NOP,24'd4000} -> NOP output valid at oPC=0, then exactly 4000 cycles oValid=0, oBusy=1, oAddress=1; then ROM[1] valid.
  - Repeat with the macro undefined -> ROM[1] follows immediately.
- Branch asserted at delay cycle 10 of 4000 -> oBusy drops next cycle; fetch resumes at target.
- Force rPC=16'hFFFF via branch -> fetches 0xFFFF then 0x0000; oPC wraps correctly.
